cond_merge4_sync: RTL and testbench

Clocked 4-to-1 merge for the drive/free pulse protocol. It is the reconvergence point after a 4-way conditional fork: each branch's drive pulse, with its data, is captured, and requests are round-robin arbitrated. One transfer at a time is forwarded downstream. The downstream free pulse is routed back only to the branch that was granted.

---
 rtl/cond_merge4_sync_if.sv | 58 +++++
 rtl/cond_merge4_sync.sv | 222 ++++++++++++++++++++++
 tb/tb_cond_merge4_sync.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_merge4_sync_if.sv
// -----------------------------------------------------------------------------
// cond_merge4_sync_if
//
// Purpose:
//   Bundles the branch-side and downstream-side drive/free signals of the
//   4-to-1 merge. Clock and reset are not part of this bundle.
//
// Signals (names as seen from the merge block):
//   i_drive0..3  : single-cycle request pulse from branch n
//   i_data0..3   : payload of branch n, sampled with its drive pulse
//   o_free0..3   : single-cycle completion pulse back to branch n
//   o_driveNext  : single-cycle request pulse to downstream
//   o_dataNext   : merged payload, held until the next grant
//   o_sel        : index of the branch owning the current/last transfer
//   i_freeNext   : single-cycle completion pulse from downstream
//   o_err        : sticky protocol-error flag
//
// Modports:
//   slave  : used by the merge block itself
//   master : used by whatever drives the branches and the downstream side
// -----------------------------------------------------------------------------
interface cond_merge4_sync_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_drive0;
   logic                  i_drive1;
   logic                  i_drive2;
   logic                  i_drive3;
   logic [DATA_WIDTH-1:0] i_data0;
   logic [DATA_WIDTH-1:0] i_data1;
   logic [DATA_WIDTH-1:0] i_data2;
   logic [DATA_WIDTH-1:0] i_data3;
   logic                  o_free0;
   logic                  o_free1;
   logic                  o_free2;
   logic                  o_free3;
   logic                  o_driveNext;
   logic [DATA_WIDTH-1:0] o_dataNext;
   logic [1:0]            o_sel;
   logic                  i_freeNext;
   logic                  o_err;

   modport slave (
      input  i_drive0, i_drive1, i_drive2, i_drive3,
      input  i_data0, i_data1, i_data2, i_data3,
      input  i_freeNext,
      output o_free0, o_free1, o_free2, o_free3,
      output o_driveNext, o_dataNext, o_sel, o_err
   );

   modport master (
      output i_drive0, i_drive1, i_drive2, i_drive3,
      output i_data0, i_data1, i_data2, i_data3,
      output i_freeNext,
      input  o_free0, o_free1, o_free2, o_free3,
      input  o_driveNext, o_dataNext, o_sel, o_err
   );
endinterface

// File: rtl/cond_merge4_sync.sv
// -----------------------------------------------------------------------------
// cond_merge4_sync
//
// Purpose:
//   Reconvergence point after a 4-way conditional fork using the drive/free
//   pulse protocol. Each branch's drive pulse is captured together with its
//   payload into a per-branch pending slot. Pending slots are arbitrated
//   round-robin and forwarded downstream one transfer at a time. The
//   downstream free pulse is routed back to the granted branch only.
//
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : asynchronous, active-high reset
//   bus    : cond_merge4_sync_if.slave bundle (branch drives/data/frees,
//            downstream driveNext/dataNext/freeNext, o_sel, o_err)
//
// Notes:
//   - Every output is a flop; nothing combinational reaches an output.
//   - A grant is decided from the registered pending flags, so a request
//     captured on edge t is grantable on edge t+1 at the earliest.
//   - A granted slot stays pending until downstream frees it; a second drive
//     on that branch during that time is an overrun unless it coincides with
//     the release edge (back-to-back accept).
// -----------------------------------------------------------------------------
module cond_merge4_sync #(
   parameter int DATA_WIDTH = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   cond_merge4_sync_if.slave  bus
);

   // --------------------------------------------------------------------------
   // FSM encoding
   // --------------------------------------------------------------------------
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // --------------------------------------------------------------------------
   // Input gathering: flatten the per-branch scalar ports into arrays so the
   // per-branch logic can be generated.
   // --------------------------------------------------------------------------
   logic [3:0]            w_drive;
   logic [DATA_WIDTH-1:0] w_data [4];

   assign w_drive   = {bus.i_drive3, bus.i_drive2, bus.i_drive1, bus.i_drive0};
   assign w_data[0] = bus.i_data0;
   assign w_data[1] = bus.i_data1;
   assign w_data[2] = bus.i_data2;
   assign w_data[3] = bus.i_data3;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic                  r_pend [4];
   logic [DATA_WIDTH-1:0] r_dreg [4];
   logic [1:0]            r_rr_ptr;

   // Registered outputs
   logic                  r_drive_next;
   logic [3:0]            r_free;
   logic [DATA_WIDTH-1:0] r_data_next;
   logic [1:0]            r_sel;
   logic                  r_err;

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   logic [3:0]            w_pend_vec;
   logic                  w_release;      // downstream frees the current owner
   logic [3:0]            w_rel_hit;      // release targets branch n
   logic [3:0]            w_overrun;      // drive on an occupied slot
   logic                  w_spurious;     // freeNext with nothing in flight
   logic [1:0]            w_grant_idx;

   // Next values of the registered outputs
   logic                  w_out_drive;
   logic [3:0]            w_out_free;
   logic [DATA_WIDTH-1:0] w_out_data;
   logic [1:0]            w_out_sel;
   logic                  w_out_err;

   assign w_release  = (r_state == ST_BUSY) && bus.i_freeNext;
   assign w_spurious = (r_state == ST_IDLE) && bus.i_freeNext;

   // --------------------------------------------------------------------------
   // Per-branch capture slots
   // --------------------------------------------------------------------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_branch
      assign w_pend_vec[gi] = r_pend[gi];
      assign w_rel_hit[gi]  = w_release && (r_sel == 2'(gi));
      // A drive coinciding with the release of its own slot is accepted;
      // otherwise a drive onto a pending slot is dropped and flagged.
      assign w_overrun[gi]  = w_drive[gi] && r_pend[gi] && !w_rel_hit[gi];

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_pend[gi] <= 1'b0;
            r_dreg[gi] <= '0;
         end else if (w_drive[gi] && !w_overrun[gi]) begin
            r_pend[gi] <= 1'b1;
            r_dreg[gi] <= w_data[gi];
         end else if (w_rel_hit[gi]) begin
            r_pend[gi] <= 1'b0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Round-robin pick: first pending slot starting at r_rr_ptr. The loop
   // walks the search order backwards so the earliest hit is written last.
   // --------------------------------------------------------------------------
   always_comb begin
      w_grant_idx = r_rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (w_pend_vec[r_rr_ptr + 2'(k)]) begin
            w_grant_idx = r_rr_ptr + 2'(k);
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM process 1: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (|w_pend_vec) begin
               w_state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.i_freeNext) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM process 3: output logic (next values for the output flops)
   // --------------------------------------------------------------------------
   always_comb begin
      w_out_drive = 1'b0;
      w_out_free  = 4'b0000;
      w_out_data  = r_data_next;
      w_out_sel   = r_sel;
      w_out_err   = r_err || (|w_overrun) || w_spurious;
      case (r_state)
         ST_IDLE: begin
            if (|w_pend_vec) begin
               w_out_drive = 1'b1;
               w_out_sel   = w_grant_idx;
               w_out_data  = r_dreg[w_grant_idx];
            end
         end
         ST_BUSY: begin
            if (bus.i_freeNext) begin
               w_out_free[r_sel] = 1'b1;
            end
         end
         default: begin
            w_out_drive = 1'b0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Output flops and round-robin pointer
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_drive_next <= 1'b0;
         r_free       <= 4'b0000;
         r_data_next  <= '0;
         r_sel        <= 2'd0;
         r_err        <= 1'b0;
         r_rr_ptr     <= 2'd0;
      end else begin
         r_drive_next <= w_out_drive;
         r_free       <= w_out_free;
         r_data_next  <= w_out_data;
         r_sel        <= w_out_sel;
         r_err        <= w_out_err;
         // The branch just served drops to lowest priority (2-bit wrap).
         if (w_release) begin
            r_rr_ptr <= r_sel + 2'd1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output mapping
   // --------------------------------------------------------------------------
   assign bus.o_driveNext = r_drive_next;
   assign bus.o_dataNext  = r_data_next;
   assign bus.o_sel       = r_sel;
   assign bus.o_err       = r_err;
   assign bus.o_free0     = r_free[0];
   assign bus.o_free1     = r_free[1];
   assign bus.o_free2     = r_free[2];
   assign bus.o_free3     = r_free[3];

endmodule

// File: tb/tb_cond_merge4_sync.sv
// -----------------------------------------------------------------------------
// tb_cond_merge4_sync
//
// Self-checking bench for cond_merge4_sync: a table of hand-derived vectors,
// directed multi-cycle sequences, and randomized traffic compared every cycle
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_cond_merge4_sync;
   localparam int DW = 32;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   cond_merge4_sync_if #(.DATA_WIDTH(DW)) bus ();

   cond_merge4_sync #(.DATA_WIDTH(DW)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model (transaction level) ----------------
   bit          m_pend [4];
   logic [31:0] m_dreg [4];
   int          m_rr;
   bit          m_busy;
   int          m_sel;
   bit          m_drv;
   logic [3:0]  m_free;
   logic [31:0] m_data;
   bit          m_err;

   function automatic void model_reset();
      for (int n = 0; n < 4; n++) begin
         m_pend[n] = 0;
         m_dreg[n] = '0;
      end
      m_rr = 0; m_busy = 0; m_sel = 0; m_drv = 0;
      m_free = '0; m_data = '0; m_err = 0;
   endfunction

   // One clock edge of the protocol: serve/release first from the old
   // state, then absorb the new requests.
   task automatic model_step();
      logic [3:0]  drv;
      logic [31:0] d [4];
      bit          fn;
      bit          was_busy;
      bit          rel;
      int          ri;
      int          g;
      drv  = {bus.i_drive3, bus.i_drive2, bus.i_drive1, bus.i_drive0};
      d[0] = bus.i_data0; d[1] = bus.i_data1;
      d[2] = bus.i_data2; d[3] = bus.i_data3;
      fn   = bus.i_freeNext;
      was_busy = m_busy;
      rel  = was_busy && fn;
      ri   = m_sel;
      g    = -1;
      if (!was_busy) begin
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
         end
      end
      m_drv  = (g >= 0);
      m_free = '0;
      if (rel) begin
         m_free[ri] = 1'b1;
         m_busy     = 0;
         m_rr       = (ri + 1) % 4;
      end
      if (g >= 0) begin
         m_data = m_dreg[g];
         m_sel  = g;
         m_busy = 1;
      end
      if (!was_busy && fn) m_err = 1;
      for (int n = 0; n < 4; n++) begin
         if (drv[n]) begin
            if (m_pend[n] && !(rel && ri == n)) m_err = 1;
            else begin
               m_pend[n] = 1;
               m_dreg[n] = d[n];
            end
         end else if (rel && ri == n) begin
            m_pend[n] = 0;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] dut_free();
      return {bus.o_free3, bus.o_free2, bus.o_free1, bus.o_free0};
   endfunction

   task automatic compare_model();
      check("model.driveNext", 64'(bus.o_driveNext), 64'(m_drv));
      check("model.free",      64'(dut_free()),      64'(m_free));
      check("model.sel",       64'(bus.o_sel),       64'(m_sel));
      check("model.dataNext",  64'(bus.o_dataNext),  64'(m_data));
      check("model.err",       64'(bus.o_err),       64'(m_err));
   endtask

   task automatic clear_inputs();
      bus.i_drive0 = 0; bus.i_drive1 = 0; bus.i_drive2 = 0; bus.i_drive3 = 0;
      bus.i_freeNext = 0;
      bus.i_data0 = $urandom; bus.i_data1 = $urandom;
      bus.i_data2 = $urandom; bus.i_data3 = $urandom;
   endtask

   // Present inputs for one edge; branch n sees data base+n.
   task automatic tick(input logic [3:0] drv, input logic [31:0] base, input bit fn);
      bus.i_drive0 = drv[0]; bus.i_drive1 = drv[1];
      bus.i_drive2 = drv[2]; bus.i_drive3 = drv[3];
      bus.i_data0 = base;        bus.i_data1 = base + 32'd1;
      bus.i_data2 = base + 32'd2; bus.i_data3 = base + 32'd3;
      bus.i_freeNext = fn;
      @(posedge i_clk);
      model_step();
      #1;
      clear_inputs();
      compare_model();
      if (bus.o_driveNext)
         $display("grant  sel=%0d data=%08h err=%0d t=%0t", bus.o_sel, bus.o_dataNext, bus.o_err, $time);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".driveNext"}, 64'(bus.o_driveNext), 64'd0);
      check({tag, ".free"},      64'(dut_free()),      64'd0);
      check({tag, ".sel"},       64'(bus.o_sel),       64'd0);
      check({tag, ".dataNext"},  64'(bus.o_dataNext),  64'd0);
      check({tag, ".err"},       64'(bus.o_err),       64'd0);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge i_clk);
      #1;
      i_rst = 1'b1;
      #2;
      check_all_zero("async_reset");
      model_reset();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  drv;
      logic [31:0] base;
      bit          fn;
      bit          e_drv;
      logic [1:0]  e_sel;
      logic [31:0] e_data;
      logic [3:0]  e_free;
      bit          e_err;
   } vec_t;

   vec_t tbl [19];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      //            drv      base          fn  drv sel  data          free     err
      tbl[0]  = '{4'b0010, 32'hA5A5_0000, 0, 0, 2'd0, 32'h0,         4'b0000, 0};
      tbl[1]  = '{4'b0000, 32'h0,         0, 1, 2'd1, 32'hA5A5_0001, 4'b0000, 0};
      tbl[2]  = '{4'b0000, 32'h0,         0, 0, 2'd1, 32'hA5A5_0001, 4'b0000, 0};
      tbl[3]  = '{4'b0000, 32'h0,         1, 0, 2'd1, 32'hA5A5_0001, 4'b0010, 0};
      tbl[4]  = '{4'b0000, 32'h0,         0, 0, 2'd1, 32'hA5A5_0001, 4'b0000, 0};
      tbl[5]  = '{4'b1111, 32'h10,        0, 0, 2'd1, 32'hA5A5_0001, 4'b0000, 0};
      tbl[6]  = '{4'b0000, 32'h0,         0, 1, 2'd2, 32'h12,        4'b0000, 0};
      tbl[7]  = '{4'b0000, 32'h0,         1, 0, 2'd2, 32'h12,        4'b0100, 0};
      tbl[8]  = '{4'b0000, 32'h0,         0, 1, 2'd3, 32'h13,        4'b0000, 0};
      tbl[9]  = '{4'b0000, 32'h0,         1, 0, 2'd3, 32'h13,        4'b1000, 0};
      tbl[10] = '{4'b0000, 32'h0,         0, 1, 2'd0, 32'h10,        4'b0000, 0};
      tbl[11] = '{4'b0001, 32'h22,        1, 0, 2'd0, 32'h10,        4'b0001, 0};
      tbl[12] = '{4'b0000, 32'h0,         0, 1, 2'd1, 32'h11,        4'b0000, 0};
      tbl[13] = '{4'b0000, 32'h0,         1, 0, 2'd1, 32'h11,        4'b0010, 0};
      tbl[14] = '{4'b0000, 32'h0,         0, 1, 2'd0, 32'h22,        4'b0000, 0};
      tbl[15] = '{4'b0000, 32'h0,         0, 0, 2'd0, 32'h22,        4'b0000, 0};
      tbl[16] = '{4'b0001, 32'h55,        0, 0, 2'd0, 32'h22,        4'b0000, 1};
      tbl[17] = '{4'b0000, 32'h0,         1, 0, 2'd0, 32'h22,        4'b0001, 1};
      tbl[18] = '{4'b0000, 32'h0,         1, 0, 2'd0, 32'h22,        4'b0000, 1};

      clear_inputs();
      model_reset();
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      check_all_zero("reset");
      i_rst = 1'b0;

      // ---- table-driven vectors ----
      for (int i = 0; i < 19; i++) begin
         tick(tbl[i].drv, tbl[i].base, tbl[i].fn);
         check($sformatf("tbl%0d.driveNext", i), 64'(bus.o_driveNext), 64'(tbl[i].e_drv));
         check($sformatf("tbl%0d.sel", i),       64'(bus.o_sel),       64'(tbl[i].e_sel));
         check($sformatf("tbl%0d.dataNext", i),  64'(bus.o_dataNext),  64'(tbl[i].e_data));
         check($sformatf("tbl%0d.free", i),      64'(dut_free()),      64'(tbl[i].e_free));
         check($sformatf("tbl%0d.err", i),       64'(bus.o_err),       64'(tbl[i].e_err));
      end

      // ---- simultaneous requests from reset: order 0,1,2,3 twice ----
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         tick(4'b1111, 32'h10, 0);
         for (int k = 0; k < 4; k++) begin
            tick(4'b0000, 32'h0, 0);
            check("simul.driveNext", 64'(bus.o_driveNext), 64'd1);
            check("simul.sel",       64'(bus.o_sel),       64'(k));
            check("simul.dataNext",  64'(bus.o_dataNext),  64'(32'h10 + k));
            tick(4'b0000, 32'h0, 0);
            tick(4'b0000, 32'h0, 1);
            check("simul.free", 64'(dut_free()), 64'(4'b0001 << k));
         end
      end

      // ---- fairness: rr_ptr=3 with pend0/pend3 → 3 then 0 ----
      tick(4'b0100, 32'h0, 0);
      tick(4'b0000, 32'h0, 0);
      tick(4'b0000, 32'h0, 1);            // release branch 2, rr_ptr -> 3
      tick(4'b1001, 32'h40, 0);
      tick(4'b0000, 32'h0, 0);
      check("fair.first_sel", 64'(bus.o_sel), 64'd3);
      check("fair.first_data", 64'(bus.o_dataNext), 64'h43);
      tick(4'b0000, 32'h0, 1);
      tick(4'b0000, 32'h0, 0);
      check("fair.second_sel", 64'(bus.o_sel), 64'd0);
      check("fair.second_data", 64'(bus.o_dataNext), 64'h40);
      tick(4'b0000, 32'h0, 1);

      // ---- overrun: second drive on branch 2 keeps first data ----
      do_reset();
      tick(4'b0001, 32'h0, 0);
      tick(4'b0000, 32'h0, 0);            // grant branch 0, BUSY
      tick(4'b0100, 32'hA8, 0);           // branch 2 data 0xAA
      check("ovr.err_before", 64'(bus.o_err), 64'd0);
      tick(4'b0100, 32'hB9, 0);           // branch 2 data 0xBB, overrun
      check("ovr.err_set", 64'(bus.o_err), 64'd1);
      tick(4'b0000, 32'h0, 1);
      tick(4'b0000, 32'h0, 0);
      check("ovr.sel", 64'(bus.o_sel), 64'd2);
      check("ovr.data", 64'(bus.o_dataNext), 64'hAA);
      tick(4'b0000, 32'h0, 1);
      tick(4'b0000, 32'h0, 0);
      check("ovr.err_sticky", 64'(bus.o_err), 64'd1);

      // ---- reset mid-transfer with pend0/pend3 set ----
      do_reset();
      tick(4'b0001, 32'h0, 0);
      tick(4'b0000, 32'h0, 0);            // BUSY on branch 0, pend0 still 1
      tick(4'b1000, 32'h0, 0);            // pend3
      do_reset();
      for (int c = 0; c < 3; c++) begin
         tick(4'b0000, 32'h0, 0);
         check_all_zero("rst_mid");
      end
      tick(4'b1000, 32'h3000, 0);
      tick(4'b0000, 32'h0, 0);
      check("rst_mid.grant", 64'(bus.o_driveNext), 64'd1);
      check("rst_mid.sel",   64'(bus.o_sel),       64'd3);
      check("rst_mid.data",  64'(bus.o_dataNext),  64'h3003);
      tick(4'b0000, 32'h0, 1);

      // ---- randomized traffic against the model ----
      for (int c = 0; c < 1500; c++) begin
         logic [3:0] drv;
         bit         fn;
         for (int n = 0; n < 4; n++) drv[n] = ($urandom_range(0, 3) == 0);
         if (m_busy) fn = ($urandom_range(0, 2) == 0);
         else        fn = ($urandom_range(0, 30) == 0);
         tick(drv, $urandom, fn);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
